conv_out_drain: RTL and testbench

CONV_OUT_DRAIN -- requirements
Module: conv_out_drain

---
 rtl/conv_out_drain.sv | 143 ++++++++++++++
 tb/tb_conv_out_drain.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_out_drain.sv
// conv_out_drain: captures a ROWS x COLS accumulator tile from a systolic array and streams
// it out one requantized pixel per accepted beat (valid/ready), in row-major order.
//
// Ports:
//   CLK        sole clock, rising edge
//   RST        synchronous active-high reset
//   LOAD       one-cycle pulse, ACC_IN holds a valid tile
//   ACC_IN     flattened tile, element (r,c) at [(r*COLS+c)*ACC_W +: ACC_W]
//   OUT_READY  downstream accepts the current beat
//   OUT_VALID  beat valid (high exactly while streaming)
//   OUT_DATA   requantized pixel: sat(element >>> SHIFT), optional ReLU
//   OUT_IDX    row-major index of the current beat
//   OUT_LAST   current beat is the final element
//   DONE       one-cycle pulse after the final beat is accepted
//   OVERRUN    sticky, a LOAD arrived while streaming and was dropped
//   STATE      current FSM state code
module conv_out_drain #(
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int ACC_W = 20,
    parameter int OUT_W = 8,
    parameter int SHIFT = 4,
    parameter int RELU  = 0
) (
    input  logic                                CLK,
    input  logic                                RST,
    input  logic                                LOAD,
    input  logic [ROWS*COLS*ACC_W-1:0]          ACC_IN,
    input  logic                                OUT_READY,
    output logic                                OUT_VALID,
    output logic [OUT_W-1:0]                    OUT_DATA,
    output logic [$clog2(ROWS*COLS)-1:0]        OUT_IDX,
    output logic                                OUT_LAST,
    output logic                                DONE,
    output logic                                OVERRUN,
    output logic [1:0]                          STATE
);

    localparam int NUM_EL = ROWS * COLS;
    localparam int IDX_W  = $clog2(NUM_EL);
    localparam int TILE_W = NUM_EL * ACC_W;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_EL - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StStream = 2'd1,
        StDone   = 2'd2
    } state_e;

    state_e                   state_q, state_d;
    logic [TILE_W-1:0]        tile_q, tile_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic                     overrun_q, overrun_d;
    logic [OUT_W-1:0]         data_q, data_d;
    logic                     last_q, last_d;
    logic signed [ACC_W-1:0]  elem;
    logic signed [ACC_W-1:0]  shifted;

    // Next-state logic. The output pixel is computed from the *next* tile/index so that
    // OUT_DATA is registered and lines up with OUT_VALID/OUT_IDX without a pipeline bubble.
    always_comb begin
        state_d   = state_q;
        tile_d    = tile_q;
        idx_d     = idx_q;
        overrun_d = overrun_q;

        case (state_q)
            StIdle, StDone: begin
                if (LOAD) begin
                    tile_d  = ACC_IN;
                    idx_d   = '0;
                    state_d = StStream;
                end else begin
                    state_d = StIdle;
                end
            end
            StStream: begin
                // A tile is already in flight; drop the new one and flag it.
                if (LOAD) begin
                    overrun_d = 1'b1;
                end
                if (OUT_READY) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = StDone;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        elem    = tile_d[idx_d*ACC_W +: ACC_W];
        shifted = elem >>> SHIFT;

        if (shifted > SAT_MAX) begin
            data_d = SAT_MAX[OUT_W-1:0];
        end else if (shifted < SAT_MIN) begin
            data_d = SAT_MIN[OUT_W-1:0];
        end else begin
            data_d = shifted[OUT_W-1:0];
        end

        if ((RELU != 0) && (shifted < 0)) begin
            data_d = '0;
        end

        if (state_d != StStream) begin
            data_d = '0;
        end
        last_d = (state_d == StStream) && (idx_d == LAST_IDX);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= StIdle;
            tile_q    <= '0;
            idx_q     <= '0;
            overrun_q <= 1'b0;
            data_q    <= '0;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tile_q    <= tile_d;
            idx_q     <= idx_d;
            overrun_q <= overrun_d;
            data_q    <= data_d;
            last_q    <= last_d;
        end
    end

    assign OUT_VALID = (state_q == StStream);
    assign DONE      = (state_q == StDone);
    assign STATE     = state_q;
    assign OUT_IDX   = idx_q;
    assign OUT_DATA  = data_q;
    assign OUT_LAST  = last_q;
    assign OVERRUN   = overrun_q;

endmodule

// File: tb/tb_conv_out_drain.sv
// Self-checking bench for conv_out_drain: two instances (RELU=0 and RELU=1) share stimulus;
// expected pixels come from a per-element arithmetic model of the requantization rule.
module tb_conv_out_drain;

    localparam int ROWS   = 4;
    localparam int COLS   = 4;
    localparam int ACC_W  = 20;
    localparam int OUT_W  = 8;
    localparam int SHIFT  = 4;
    localparam int NUM_EL = ROWS * COLS;
    localparam int IDX_W  = $clog2(NUM_EL);
    localparam int PIX_MAX = (1 << (OUT_W - 1)) - 1;
    localparam int PIX_MIN = -(1 << (OUT_W - 1));

    logic                      CLK = 1'b0;
    logic                      RST = 1'b1;
    logic                      LOAD = 1'b0;
    logic [NUM_EL*ACC_W-1:0]   ACC_IN = '0;
    logic                      OUT_READY = 1'b0;

    logic                      out_valid, out_last, done, overrun;
    logic [OUT_W-1:0]          out_data;
    logic [IDX_W-1:0]          out_idx;
    logic [1:0]                state;

    logic                      r_valid, r_last, r_done, r_overrun;
    logic [OUT_W-1:0]          r_data;
    logic [IDX_W-1:0]          r_idx;
    logic [1:0]                r_state;

    int n_tests = 0;
    int n_fail  = 0;

    int  pend[NUM_EL];   // tile about to be loaded
    int  model[NUM_EL];  // tile the DUT should currently be streaming
    bit  exp_overrun = 1'b0;

    always #5 CLK = ~CLK;

    conv_out_drain #(
        .ROWS(ROWS), .COLS(COLS), .ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .RELU(0)
    ) u_dut (
        .CLK(CLK), .RST(RST), .LOAD(LOAD), .ACC_IN(ACC_IN), .OUT_READY(OUT_READY),
        .OUT_VALID(out_valid), .OUT_DATA(out_data), .OUT_IDX(out_idx), .OUT_LAST(out_last),
        .DONE(done), .OVERRUN(overrun), .STATE(state)
    );

    conv_out_drain #(
        .ROWS(ROWS), .COLS(COLS), .ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .RELU(1)
    ) u_dut_relu (
        .CLK(CLK), .RST(RST), .LOAD(LOAD), .ACC_IN(ACC_IN), .OUT_READY(OUT_READY),
        .OUT_VALID(r_valid), .OUT_DATA(r_data), .OUT_IDX(r_idx), .OUT_LAST(r_last),
        .DONE(r_done), .OVERRUN(r_overrun), .STATE(r_state)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Floor division by 2^SHIFT, then clamp to the signed output range.
    function automatic int requant(input int v, input bit relu);
        int q;
        q = v >>> SHIFT;
        if (q > PIX_MAX) q = PIX_MAX;
        if (q < PIX_MIN) q = PIX_MIN;
        if (relu && q < 0) q = 0;
        return q;
    endfunction

    function automatic int rand_elem();
        if ($urandom_range(0, 1) == 1)
            return int'($urandom_range(0, 8191)) - 4096;
        return int'($urandom_range(0, (1 << ACC_W) - 1)) - (1 << (ACC_W - 1));
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_pend();
        for (int i = 0; i < NUM_EL; i++) begin
            ACC_IN[i*ACC_W +: ACC_W] = pend[i][ACC_W-1:0];
        end
    endtask

    task automatic scramble_acc_in();
        for (int i = 0; i < NUM_EL; i++) begin
            ACC_IN[i*ACC_W +: ACC_W] = ACC_W'($urandom);
        end
    endtask

    task automatic random_pend();
        for (int i = 0; i < NUM_EL; i++) pend[i] = rand_elem();
    endtask

    // Pulse LOAD with the pending tile; afterwards the first beat should be visible.
    task automatic load_pend();
        drive_pend();
        LOAD = 1'b1;
        tick();
        LOAD = 1'b0;
        for (int i = 0; i < NUM_EL; i++) model[i] = pend[i];
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, int'(state), 0);
        check({tag, "_valid"}, int'(out_valid), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_overrun"}, int'(overrun), 0);
        check({tag, "_idx"}, int'(out_idx), 0);
        check({tag, "_last"}, int'(out_last), 0);
        check({tag, "_data"}, int'(out_data), 0);
    endtask

    // mode 0: ready always high; 1: ready pattern 1,0,0 repeating; 2: random ready.
    // rst_at >= 0 asserts RST when that index is on the bus. load_in_done pulses LOAD
    // with a fresh pending tile during the DONE cycle.
    task automatic drain(input int mode, input bit do_overrun, input int rst_at,
                         input bit load_in_done);
        int exp_idx = 0;
        int cycles  = 0;
        bit rdy;
        while (exp_idx < NUM_EL && cycles < 200) begin
            check("beat_valid", int'(out_valid), 1);
            check("beat_state", int'(state), 1);
            check("beat_idx", int'(out_idx), exp_idx);
            check("beat_data", int'($signed(out_data)), requant(model[exp_idx], 1'b0));
            check("beat_data_relu", int'($signed(r_data)), requant(model[exp_idx], 1'b1));
            check("beat_last", int'(out_last), (exp_idx == NUM_EL - 1) ? 1 : 0);
            check("beat_done", int'(done), 0);
            if (rst_at == exp_idx) begin
                RST = 1'b1;
                tick();
                RST = 1'b0;
                exp_overrun = 1'b0;
                check_reset_outputs("midrst");
                for (int k = 0; k < 4; k++) begin
                    tick();
                    check("post_rst_done", int'(done), 0);
                    check("post_rst_valid", int'(out_valid), 0);
                end
                return;
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cycles % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            OUT_READY = rdy;
            scramble_acc_in();
            LOAD = (do_overrun && cycles == 2);
            if (LOAD) exp_overrun = 1'b1;
            tick();
            LOAD = 1'b0;
            cycles++;
            if (rdy) exp_idx++;
            if (do_overrun && cycles == 3) check("overrun_set", int'(overrun), 1);
        end
        if (exp_idx < NUM_EL) begin
            check("drain_timeout", exp_idx, NUM_EL);
            return;
        end
        if (mode == 0) check("drain_cycles", cycles, NUM_EL);
        check("done_pulse", int'(done), 1);
        check("done_state", int'(state), 2);
        check("done_valid", int'(out_valid), 0);
        check("done_overrun", int'(overrun), int'(exp_overrun));
        check("done_relu", int'(r_done), 1);
        if (load_in_done) begin
            load_pend();
        end else begin
            OUT_READY = 1'($urandom_range(0, 1));
            tick();
            check("idle_state", int'(state), 0);
            check("idle_done", int'(done), 0);
            check("idle_valid", int'(out_valid), 0);
        end
    endtask

    initial begin
        // Reset, with LOAD coincident so it must be ignored.
        RST  = 1'b1;
        LOAD = 1'b1;
        random_pend();
        drive_pend();
        tick();
        tick();
        LOAD = 1'b0;
        check_reset_outputs("reset");
        RST = 1'b0;
        tick();
        check("idle_after_reset", int'(state), 0);

        // Ramp tile: element i = i*16 gives pixels 0..15.
        for (int i = 0; i < NUM_EL; i++) pend[i] = i * 16;
        load_pend();
        drain(0, 1'b0, -1, 1'b0);

        // Saturation / rounding corners at the head of the tile.
        random_pend();
        pend[0] = 4000;
        pend[1] = -4000;
        pend[2] = -17;
        pend[3] = 15;
        load_pend();
        drain(0, 1'b0, -1, 1'b0);

        // Backpressure pattern.
        random_pend();
        load_pend();
        drain(1, 1'b0, -1, 1'b0);

        // Dropped LOAD mid-stream, then a LOAD in the DONE cycle.
        random_pend();
        load_pend();
        random_pend();
        drain(2, 1'b1, -1, 1'b1);
        drain(0, 1'b0, -1, 1'b0);

        // Reset part-way through a stream, then a clean restart.
        random_pend();
        load_pend();
        drain(0, 1'b0, 7, 1'b0);
        random_pend();
        load_pend();
        drain(2, 1'b0, -1, 1'b0);

        // Random tiles with random backpressure.
        for (int t = 0; t < 6; t++) begin
            random_pend();
            load_pend();
            drain(2, 1'b0, -1, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
